// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding, address-space tags, widths.
package mem_arb_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_I_LO = 3'd1;
  localparam logic [2:0] ST_I_HI = 3'd2;
  localparam logic [2:0] ST_D_RD = 3'd3;
  localparam logic [2:0] ST_D_WR = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    I_LO = ST_I_LO,
    I_HI = ST_I_HI,
    D_RD = ST_D_RD,
    D_WR = ST_D_WR
  } arb_state_e;

  localparam logic DSPACE = 1'b1;
  localparam logic ISPACE = 1'b0;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned IW  = 16;
  localparam int unsigned MAW = 9;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide memory between a 16-bit instruction fetch port and an 8-bit data port.
// Data wins ties; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           g_clk,
  input  logic           g_clr,
  input  logic           i_req,
  input  logic [AW-1:0]  i_addr,
  output logic           i_odv,
  output logic [IW-1:0]  i_data,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [AW-1:0]  d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_odv,
  output logic [DW-1:0]  d_rdata,
  output logic           m_cs,
  output logic           m_we,
  output logic [MAW-1:0] m_addr,
  output logic [DW-1:0]  m_wdata,
  input  logic [DW-1:0]  m_rdata,
  output logic           busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [MAW-1:0]   addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    lo_q, lo_d;
  logic [IW-1:0]    i_data_q, i_data_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic             i_odv_q, i_odv_d;
  logic             d_odv_q, d_odv_d;
  logic             m_cs_q, m_cs_d;
  logic             m_we_q, m_we_d;
  logic [MAW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]    m_wdata_q, m_wdata_d;
  logic             busy_q, busy_d;

  logic beat_last_c;
  logic d_grant_c;
  logic i_grant_c;
  logic i_addr_unused;

  // Instruction space is 128 words; the top address bit has no meaning.
  assign i_addr_unused = i_addr[AW-1];

  assign beat_last_c = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign d_grant_c   = d_req && (!i_req || (starve_q < STV_W'(STARVE_MAX)));
  assign i_grant_c   = i_req && (!d_req || (starve_q == STV_W'(STARVE_MAX)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_odv_d   = 1'b0;
    d_odv_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_grant_c) begin
          state_d = d_we ? D_WR : D_RD;
          addr_d  = {DSPACE, d_addr};
          wdata_d = d_wdata;
          if (i_req) starve_d = starve_q + STV_W'(1);
        end else if (i_grant_c) begin
          state_d  = I_LO;
          addr_d   = {ISPACE, i_addr[AW-2:0], 1'b0};
          starve_d = '0;
        end
      end
      I_LO, I_HI, D_RD, D_WR: begin
        if (!beat_last_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          case (state_q)
            I_LO: begin
              lo_d    = m_rdata;
              state_d = I_HI;
            end
            I_HI: begin
              i_data_d = {m_rdata, lo_q};
              i_odv_d  = 1'b1;
              state_d  = IDLE;
            end
            D_RD: begin
              d_rdata_d = m_rdata;
              d_odv_d   = 1'b1;
              state_d   = IDLE;
            end
            default: begin
              d_odv_d = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory-side outputs follow the state being entered so they line up with the beat.
    m_cs_d    = (state_d != IDLE);
    m_we_d    = (state_d == D_WR);
    busy_d    = m_cs_d;
    m_wdata_d = m_we_d ? wdata_d : '0;
    if (state_d == I_HI)  m_addr_d = {addr_d[MAW-1:1], 1'b1};
    else if (m_cs_d)      m_addr_d = addr_d;
    else                  m_addr_d = '0;
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_odv_q   <= 1'b0;
      d_odv_q   <= 1'b0;
      m_cs_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_odv_q   <= i_odv_d;
      d_odv_q   <= d_odv_d;
      m_cs_q    <= m_cs_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign i_odv   = i_odv_q;
  assign i_data  = i_data_q;
  assign d_odv   = d_odv_q;
  assign d_rdata = d_rdata_q;
  assign m_cs    = m_cs_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and 2) against a transaction-schedule model,
// plus literal expectations pinned to specific cycles.
module tb_mem_arbiter;

  localparam int SMAX = 4;
  localparam int S_DODV = 0, S_DRD = 1, S_IODV = 2, S_IDATA = 3, S_MCS = 4;
  localparam int S_MWE = 5, S_MADDR = 6, S_BUSY = 7, S_MWD = 8, NSIG = 9;
  localparam int K_NONE = 0, K_DRD = 1, K_DWR = 2, K_IF = 3;
  localparam int NPIN = 128;

  logic g_clk;
  logic g_clr;

  logic [1:0]       i_req, i_odv, d_req, d_we, d_odv, m_cs, m_we, busy;
  logic [1:0][7:0]  i_addr, d_addr, d_wdata, d_rdata, m_wdata, m_rdata;
  logic [1:0][15:0] i_data;
  logic [1:0][8:0]  m_addr;

  logic [7:0] mem [2][512];

  typedef struct {
    int k;
    int at;
    int sel;
    int val;
  } pin_t;

  pin_t pins [NPIN];
  int   npins = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Model state: one scheduled transaction per instance, described by its cycle window.
  int         md_kind [2];
  int         md_start [2];
  int         md_end [2];
  int         md_starve [2];
  logic [8:0] md_adr [2];
  logic [7:0] md_wd [2];
  logic [7:0] x_drd [2];
  logic [15:0] x_id [2];
  logic [7:0] mm [2][512];
  int         lat_v;
  logic       bz_v;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.MEM_LAT(k + 1), .STARVE_MAX(SMAX)) u_dut (
      .g_clk   (g_clk),
      .g_clr   (g_clr),
      .i_req   (i_req[k]),
      .i_addr  (i_addr[k]),
      .i_odv   (i_odv[k]),
      .i_data  (i_data[k]),
      .d_req   (d_req[k]),
      .d_we    (d_we[k]),
      .d_addr  (d_addr[k]),
      .d_wdata (d_wdata[k]),
      .d_odv   (d_odv[k]),
      .d_rdata (d_rdata[k]),
      .m_cs    (m_cs[k]),
      .m_we    (m_we[k]),
      .m_addr  (m_addr[k]),
      .m_wdata (m_wdata[k]),
      .m_rdata (m_rdata[k]),
      .busy    (busy[k])
    );
    assign m_rdata[k] = mem[k][m_addr[k]];
  end

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  function automatic logic [7:0] init_byte(int a);
    case (a)
      'h1A5:   return 8'h3C;
      'h014:   return 8'hCD;
      'h015:   return 8'hAB;
      default: return 8'(a * 37 + 11);
    endcase
  endfunction

  // Memory contents are restored whenever reset is held.
  always @(posedge g_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!g_clr) begin
        for (int a = 0; a < 512; a++) mem[k][a] <= init_byte(a);
      end else if (m_cs[k] && m_we[k]) begin
        mem[k][m_addr[k]] <= m_wdata[k];
      end
    end
  end

  function automatic int get_sig(int k, int sel);
    case (sel)
      S_DODV:  return int'(d_odv[k]);
      S_DRD:   return int'(d_rdata[k]);
      S_IODV:  return int'(i_odv[k]);
      S_IDATA: return int'(i_data[k]);
      S_MCS:   return int'(m_cs[k]);
      S_MWE:   return int'(m_we[k]);
      S_MADDR: return int'(m_addr[k]);
      S_BUSY:  return int'(busy[k]);
      default: return int'(m_wdata[k]);
    endcase
  endfunction

  function automatic string sig_name(int sel);
    case (sel)
      S_DODV:  return "d_odv";
      S_DRD:   return "d_rdata";
      S_IODV:  return "i_odv";
      S_IDATA: return "i_data";
      S_MCS:   return "m_cs";
      S_MWE:   return "m_we";
      S_MADDR: return "m_addr";
      S_BUSY:  return "busy";
      default: return "m_wdata";
    endcase
  endfunction

  function automatic void chk(string tag, int k, int sel, int exp);
    int got;
    got = get_sig(k, sel);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s.%s inst=%0d cyc=%0d got=%0h want=%0h", tag, sig_name(sel), k, cyc, got, exp);
    end
  endfunction

  // Compare against the model, then advance it with this cycle's inputs.
  always @(negedge g_clk) begin
    for (int k = 0; k < 2; k++) begin
      lat_v = k + 1;
      if (!g_clr) begin
        for (int s = 0; s < NSIG; s++) chk("reset", k, s, 0);
        md_kind[k]   = K_NONE;
        md_start[k]  = 0;
        md_end[k]    = 0;
        md_starve[k] = 0;
        x_drd[k]     = 8'h00;
        x_id[k]      = 16'h0000;
        for (int a = 0; a < 512; a++) mm[k][a] = init_byte(a);
      end else begin
        bz_v = (md_kind[k] != K_NONE) && (cyc >= md_start[k]) && (cyc < md_end[k]);
        chk("model", k, S_BUSY, int'(bz_v));
        chk("model", k, S_MCS, int'(bz_v));
        chk("model", k, S_MWE, int'(bz_v && md_kind[k] == K_DWR));
        chk("model", k, S_DODV, int'(cyc == md_end[k] && (md_kind[k] == K_DRD || md_kind[k] == K_DWR)));
        chk("model", k, S_IODV, int'(cyc == md_end[k] && md_kind[k] == K_IF));
        chk("model", k, S_DRD, int'(x_drd[k]));
        chk("model", k, S_IDATA, int'(x_id[k]));
        if (bz_v) begin
          if (md_kind[k] == K_IF && (cyc - md_start[k]) >= lat_v)
            chk("model", k, S_MADDR, int'(md_adr[k] | 9'd1));
          else
            chk("model", k, S_MADDR, int'(md_adr[k]));
          if (md_kind[k] == K_DWR) chk("model", k, S_MWD, int'(md_wd[k]));
          if (cyc == md_end[k] - 1) begin
            case (md_kind[k])
              K_DRD:   x_drd[k] = mm[k][md_adr[k]];
              K_DWR:   mm[k][md_adr[k]] = md_wd[k];
              default: x_id[k] = {mm[k][md_adr[k] | 9'd1], mm[k][md_adr[k]]};
            endcase
          end
        end else if (d_req[k] && (!i_req[k] || md_starve[k] < SMAX)) begin
          md_kind[k]  = d_we[k] ? K_DWR : K_DRD;
          md_adr[k]   = {1'b1, d_addr[k]};
          md_wd[k]    = d_wdata[k];
          md_start[k] = cyc + 1;
          md_end[k]   = cyc + 1 + lat_v;
          if (i_req[k]) md_starve[k]++;
        end else if (i_req[k]) begin
          md_kind[k]   = K_IF;
          md_adr[k]    = {1'b0, i_addr[k][6:0], 1'b0};
          md_start[k]  = cyc + 1;
          md_end[k]    = cyc + 1 + 2 * lat_v;
          md_starve[k] = 0;
        end
      end
    end
    for (int i = 0; i < npins; i++)
      if (pins[i].at == cyc) chk("pin", pins[i].k, pins[i].sel, pins[i].val);
    cyc++;
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic pin(int k, int at, int sel, int val);
    if (npins < NPIN) begin
      pins[npins] = '{k: k, at: at, sel: sel, val: val};
      npins++;
    end
  endtask

  task automatic do_data(int k, logic we, logic [7:0] a, logic [7:0] wd);
    int lat;
    lat = k + 1;
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
    repeat (1 + lat) step();
    d_req[k] = 1'b0;
  endtask

  initial begin
    int n, lat, p;
    g_clr = 1'b0;
    i_req = '0; i_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    g_clr = 1'b1;
    step();
    pin(0, cyc, S_BUSY, 0);
    pin(1, cyc, S_IODV, 0);

    for (int k = 0; k < 2; k++) begin
      lat = k + 1;
      p   = 1 + lat;

      // Data read of byte 0xA5
      n = cyc;
      pin(k, n + 1, S_MADDR, 'h1A5);
      pin(k, n + 1, S_MCS, 1);
      pin(k, n + p, S_DODV, 1);
      pin(k, n + p, S_DRD, 'h3C);
      do_data(k, 1'b0, 8'hA5, 8'h00);
      step();

      // Fetch word 0x0A (top address bit set on the fast instance)
      n = cyc;
      pin(k, n + 1, S_MADDR, 'h014);
      pin(k, n + lat, S_MADDR, 'h014);
      pin(k, n + 1 + lat, S_MADDR, 'h015);
      pin(k, n + 2 * lat, S_MADDR, 'h015);
      pin(k, n + 1 + 2 * lat, S_IODV, 1);
      pin(k, n + 1 + 2 * lat, S_IDATA, 'hABCD);
      i_req[k]  = 1'b1;
      i_addr[k] = (k == 0) ? 8'h8A : 8'h0A;
      repeat (1 + 2 * lat) step();
      i_req[k] = 1'b0;
      step();

      // Write 0x5E to 0x10, then read it back
      n = cyc;
      pin(k, n + 1, S_MWE, 1);
      pin(k, n + 1, S_MADDR, 'h110);
      pin(k, n + 1, S_MWD, 'h5E);
      pin(k, n + p, S_DODV, 1);
      pin(k, n + p, S_DRD, 'h3C);
      do_data(k, 1'b1, 8'h10, 8'h5E);
      step();
      n = cyc;
      pin(k, n + 1, S_MWE, 0);
      pin(k, n + p, S_DRD, 'h5E);
      do_data(k, 1'b0, 8'h10, 8'h00);
      step();

      // Both requests held: four data grants, one forced fetch, then data again
      n = cyc;
      for (int g = 1; g <= 4; g++) pin(k, n + g * p, S_DODV, 1);
      pin(k, n + 4 * p + 1, S_MADDR, 'h014);
      pin(k, n + 4 * p + 1 + lat, S_MADDR, 'h015);
      pin(k, n + 4 * p + 1 + 2 * lat, S_IODV, 1);
      pin(k, n + 4 * p + 1 + 2 * lat, S_DODV, 0);
      pin(k, n + 4 * p + 2 + 2 * lat, S_MADDR, 'h120);
      pin(k, n + 4 * p + 1 + 2 * lat + p, S_DODV, 1);
      d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 8'h20;
      i_req[k] = 1'b1; i_addr[k] = 8'h0A;
      repeat (4 * p + 1 + 2 * lat) step();
      i_req[k] = 1'b0;
      repeat (p) step();
      d_req[k] = 1'b0;
      step();

      // Simultaneous requests with a fresh starve count; i_addr moves around the grants
      n = cyc;
      pin(k, n + 1, S_MADDR, 'h130);
      pin(k, n + p, S_DODV, 1);
      pin(k, n + p, S_IODV, 0);
      pin(k, n + p + 1, S_MADDR, 'h00C);
      pin(k, n + p + 1 + lat, S_MADDR, 'h00D);
      pin(k, n + p + 1 + 2 * lat, S_IODV, 1);
      d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 8'h30;
      i_req[k] = 1'b1; i_addr[k] = 8'h05;
      step();
      i_addr[k] = 8'h06;
      repeat (p - 1) step();
      d_req[k] = 1'b0;
      step();
      i_addr[k] = 8'h33;
      repeat (2 * lat) step();
      i_req[k] = 1'b0;
      step();
    end

    // Reset during the high-byte beat of a fetch on the slow instance
    n = cyc;
    pin(1, n + 3, S_MCS, 0);
    pin(1, n + 3, S_BUSY, 0);
    pin(1, n + 3, S_MADDR, 0);
    pin(1, n + 3, S_IDATA, 0);
    pin(1, n + 5, S_IODV, 0);
    pin(1, n + 5, S_BUSY, 0);
    pin(1, n + 6, S_IODV, 0);
    i_req[1]  = 1'b1;
    i_addr[1] = 8'h0A;
    repeat (3) step();
    #2;
    g_clr    = 1'b0;
    i_req[1] = 1'b0;
    step();
    g_clr = 1'b1;
    repeat (3) step();

    // Recovery read after reset
    n = cyc;
    pin(0, n + 2, S_DODV, 1);
    pin(0, n + 2, S_DRD, 'h3C);
    do_data(0, 1'b0, 8'hA5, 8'h00);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
